// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and constants for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;
  localparam int DEF_MISS_TIMEOUT = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / cache-miss / taken-branch stall and flush control
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MISS_TIMEOUT = DEF_MISS_TIMEOUT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WR_out,
  input  logic             EX_Branch_taken,
  input  logic             M_MemAccess,
  input  logic             D_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_M_Write,
  output logic             M_WB_Flush,
  output logic             mem_wait,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             err_timeout
);
  localparam int WAIT_W = ($clog2(MISS_TIMEOUT + 1) > 8) ? $clog2(MISS_TIMEOUT + 1) : 8;
  localparam logic [WAIT_W-1:0] TO_M1 = WAIT_W'(MISS_TIMEOUT - 1);
  state_t state_q, state_d;
  logic err_q, err_d;
  logic miss, load_use, freeze, branch, bubble, wait_inc;
  logic [WAIT_W-1:0] wait_q;
  assign miss = M_MemAccess && !D_ready;
  assign load_use = EX_MemRead && EX_WR_out != 5'd0 && (EX_WR_out == ID_Rs || EX_WR_out == ID_Rt);
  // in MEM_WAIT only D_ready releases; M_MemAccess is irrelevant there
  assign freeze = (state_q == MEM_WAIT) ? !D_ready : miss;
  assign branch = !freeze && EX_Branch_taken;
  assign bubble = !freeze && !EX_Branch_taken && load_use;
  assign wait_inc = state_q == MEM_WAIT && !D_ready;
  assign state_d = freeze ? MEM_WAIT : RUN;
  assign err_d = err_q || (MISS_TIMEOUT != 0 && wait_inc && wait_q >= TO_M1);
  assign err_timeout = err_q;
  always_comb begin
    PC_Write = rst_n && !freeze && !bubble;
    IF_ID_Write = rst_n && !freeze && !bubble;
    IF_ID_Flush = !rst_n || branch;
    ID_EX_Write = rst_n && !freeze;
    ID_EX_Flush = !rst_n || branch || bubble;
    EX_M_Write = rst_n && !freeze;
    M_WB_Flush = !rst_n || freeze;
    mem_wait = rst_n && wait_inc;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= RUN;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(freeze || bubble), .q(stall_cnt)
  );
  // held clear whenever the next state is RUN, so every miss starts from zero
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk(clk), .rst_n(rst_n && freeze), .inc(wait_inc), .q(wait_q)
  );
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench for hazard_stall_ctrl (MISS_TIMEOUT=4, CNT_W=3)
module tb_hazard_stall_ctrl;
  typedef struct packed {
    logic [7:0] ctrl;
    logic [2:0] cnt;
    logic       err;
  } exp_t;
  localparam logic [7:0] C_RST = 8'b0010_1010;
  localparam logic [7:0] C_RUN = 8'b1101_0100;
  localparam logic [7:0] C_LU  = 8'b0001_1100;
  localparam logic [7:0] C_BR  = 8'b1111_1100;
  localparam logic [7:0] C_FRZ = 8'b0000_0010;
  localparam logic [7:0] C_MW  = 8'b0000_0011;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] ID_Rs, ID_Rt, EX_WR_out;
  logic EX_MemRead, EX_Branch_taken, M_MemAccess, D_ready;
  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_M_Write, M_WB_Flush, mem_wait;
  logic [2:0] stall_cnt;
  logic err_timeout;
  int errors = 0;
  int checks = 0;
  int mon_step = 0;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  hazard_stall_ctrl #(.MISS_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_MemRead(EX_MemRead),
    .EX_WR_out(EX_WR_out), .EX_Branch_taken(EX_Branch_taken), .M_MemAccess(M_MemAccess),
    .D_ready(D_ready), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush), .EX_M_Write(EX_M_Write),
    .M_WB_Flush(M_WB_Flush), .mem_wait(mem_wait), .stall_cnt(stall_cnt), .err_timeout(err_timeout)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic rn, input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                       input logic [4:0] wr, input logic br, input logic ma, input logic dr,
                       input logic [7:0] ctrl, input logic [2:0] cnt, input logic er);
    @(posedge clk);
    #1;
    rst_n = rn; ID_Rs = rs; ID_Rt = rt; EX_MemRead = mr; EX_WR_out = wr;
    EX_Branch_taken = br; M_MemAccess = ma; D_ready = dr;
    sb.push_back('{ctrl: ctrl, cnt: cnt, err: er});
  endtask
  always @(negedge clk)
    if (sb.size() != 0) begin
      e = sb.pop_front();
      mon_step++;
      check($sformatf("ctrl@%0d", mon_step),
            {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_M_Write, M_WB_Flush, mem_wait}, e.ctrl);
      check($sformatf("stall_cnt@%0d", mon_step), stall_cnt, e.cnt);
      check($sformatf("err_timeout@%0d", mon_step), err_timeout, e.err);
    end
  initial begin
    rst_n = 1'b0; ID_Rs = 0; ID_Rt = 0; EX_MemRead = 0; EX_WR_out = 0;
    EX_Branch_taken = 0; M_MemAccess = 0; D_ready = 1;
    @(posedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1, C_RST, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 0);
    drive(1, 8, 0, 1, 8, 0, 0, 1, C_LU,  0, 0);
    drive(1, 8, 0, 0, 8, 0, 0, 1, C_RUN, 1, 0);
    drive(1, 8, 9, 1, 9, 0, 0, 1, C_LU,  1, 0);
    drive(1, 0, 0, 1, 0, 0, 0, 1, C_RUN, 2, 0);
    drive(1, 8, 0, 0, 8, 0, 0, 1, C_RUN, 2, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1, C_RUN, 2, 0);
    drive(1, 8, 0, 1, 8, 1, 0, 1, C_BR,  2, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, C_RUN, 2, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, C_RST, 2, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0, C_MW,  1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0, C_MW,  2, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1, C_RUN, 3, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, C_RUN, 3, 0);
    drive(1, 8, 0, 1, 8, 1, 1, 0, C_FRZ, 3, 0);
    drive(1, 8, 0, 1, 8, 1, 1, 0, C_MW,  4, 0);
    drive(1, 8, 0, 1, 8, 1, 1, 1, C_BR,  5, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, C_RUN, 5, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, C_RST, 5, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0, 0);
    for (int i = 1; i <= 8; i++)
      drive(1, 0, 0, 0, 0, 0, 1, 0, C_MW, (i > 7) ? 3'd7 : 3'(i), i >= 5);
    drive(0, 0, 0, 0, 0, 0, 1, 0, C_RST, 7, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0);
    for (int i = 0; i < 10; i++)
      drive(1, 8, 0, 1, 8, 0, 0, 1, C_LU, (i > 7) ? 3'd7 : 3'(i), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, C_RUN, 7, 0);
    repeat (3) @(posedge clk);
    check("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
